// File: rtl/muldiv_pkg.sv
// Shared constants and state type for the MULTU/DIVU sequencer.
// The ALU op codes match the shared execute-stage ALU encoding.
package muldiv_pkg;

  localparam int STEPS = 16;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One shift-add (MULTU) or restoring-divide (DIVU) iteration: ALU operand
// selection plus the next HI/LO computed from the shared ALU's result.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_opnd,
  input  logic [WIDTH-1:0] i_alu_out,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [2:0]       o_alu_ctrl,
  output logic [WIDTH-1:0] o_hi_next,
  output logic [WIDTH-1:0] o_lo_next
);

  logic [WIDTH-1:0] w_div_a;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_ge;

  assign w_div_a = {i_hi[WIDTH-2:0], i_lo[WIDTH-1]};

  // Operands depend only on registered state, never on the ALU result.
  always_comb begin
    o_alu_b = i_opnd;
    if (i_op == OP_MULTU) begin
      o_alu_a    = i_hi;
      o_alu_ctrl = ALU_ADD;
    end else begin
      o_alu_a    = w_div_a;
      o_alu_ctrl = ALU_SUB;
    end
  end

  always_comb begin
    w_sum     = i_hi;
    w_carry   = 1'b0;
    w_ge      = 1'b0;
    o_hi_next = i_hi;
    o_lo_next = i_lo;
    if (i_op == OP_MULTU) begin
      // Carry out of a 16-bit add shows up as a wrapped (smaller) sum.
      if (i_lo[0]) begin
        w_sum   = i_alu_out;
        w_carry = (i_alu_out < i_hi);
      end
      o_hi_next = {w_carry, w_sum[WIDTH-1:1]};
      o_lo_next = {w_sum[0], i_lo[WIDTH-1:1]};
    end else begin
      // hi[15] set means the shifted partial remainder exceeds 16 bits.
      w_ge      = i_hi[WIDTH-1] | (w_div_a >= i_opnd);
      o_hi_next = w_ge ? i_alu_out : w_div_a;
      o_lo_next = {i_lo[WIDTH-2:0], w_ge};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// MULTU/DIVU sequencer borrowing the shared 16-bit ALU for 16 steps.
// Optional: define MULDIV_EARLY_EXIT_EN to skip the steps for MULTU by zero.
//   state | meaning
//   IDLE  | waiting for start; hi/lo hold the last result
//   STEP  | one multiply/divide iteration per cycle, ALU owned
//   FIN   | result valid, done pulse
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_alu_own,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [2:0]       o_alu_ctrl,
  input  logic [WIDTH-1:0] i_alu_out
);

  state_t           r_state, w_next_state;
  logic             r_op;
  logic [WIDTH-1:0] r_hi, r_lo, r_opnd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dbz;

  logic             w_div0, w_mul_zero, w_skip, w_last;
  logic [WIDTH-1:0] w_step_a, w_step_b, w_hi_next, w_lo_next;
  logic [2:0]       w_step_ctrl;

`ifdef MULDIV_EARLY_EXIT_EN
  assign w_mul_zero = (i_rs == '0) || (i_rt == '0);
`else
  assign w_mul_zero = 1'b0;
`endif

  assign w_div0 = (i_op == OP_DIVU) && (i_rt == '0);
  assign w_skip = w_div0 || ((i_op == OP_MULTU) && w_mul_zero);
  assign w_last = (r_cnt == CNT_W'(STEPS - 1));

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_op      (r_op),
    .i_hi      (r_hi),
    .i_lo      (r_lo),
    .i_opnd    (r_opnd),
    .i_alu_out (i_alu_out),
    .o_alu_a   (w_step_a),
    .o_alu_b   (w_step_b),
    .o_alu_ctrl(w_step_ctrl),
    .o_hi_next (w_hi_next),
    .o_lo_next (w_lo_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_alu_own    = 1'b0;
    o_alu_a      = '0;
    o_alu_b      = '0;
    o_alu_ctrl   = ALU_ADD;
    case (r_state)
      IDLE: begin
        if (i_start) w_next_state = w_skip ? FIN : STEP;
      end
      STEP: begin
        o_busy     = 1'b1;
        o_alu_own  = 1'b1;
        o_alu_a    = w_step_a;
        o_alu_b    = w_step_b;
        o_alu_ctrl = w_step_ctrl;
        if (w_last) w_next_state = FIN;
      end
      FIN: begin
        o_busy       = 1'b1;
        o_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op   <= OP_MULTU;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
      r_cnt  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_op   <= i_op;
            r_cnt  <= '0;
            r_dbz  <= w_div0;
            r_hi   <= w_div0 ? i_rs : '0;
            r_opnd <= (i_op == OP_DIVU) ? i_rt : i_rs;
            if (w_skip)
              r_lo <= w_div0 ? '1 : '0;
            else
              r_lo <= (i_op == OP_DIVU) ? i_rs : i_rt;
          end
        end
        STEP: begin
          r_hi  <= w_hi_next;
          r_lo  <= w_lo_next;
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table, scoreboard queue and
// hand sequences for ignored starts and reset abort. Honors MULDIV_EARLY_EXIT_EN.
module tb_muldiv_seq;
  import muldiv_pkg::*;

`ifdef MULDIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic        op;
    logic [15:0] rs;
    logic [15:0] rt;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
    int          again;
  } vec_t;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, op;
  logic [15:0] rs, rt;
  logic        busy, done, dbz, alu_own;
  logic [15:0] hi, lo, alu_a, alu_b, alu_out;
  logic [2:0]  alu_ctrl;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t tbl[15];

  always #5 clk = ~clk;

  // Shared ALU model: ADD or SUB, modulo 2^16.
  assign alu_out = (alu_ctrl == 3'b010) ? (alu_a + alu_b) : (alu_a - alu_b);

  muldiv_seq dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_op         (op),
    .i_rs         (rs),
    .i_rt         (rt),
    .o_busy       (busy),
    .o_done       (done),
    .o_div_by_zero(dbz),
    .o_hi         (hi),
    .o_lo         (lo),
    .o_alu_own    (alu_own),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_ctrl   (alu_ctrl),
    .i_alu_out    (alu_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic run_op(input vec_t v, input string name);
    exp_t e, got;
    int   cyc, busy_cnt, own_cnt;
    e.hi  = v.hi;
    e.lo  = v.lo;
    e.dbz = v.dbz;
    if (v.op == OP_DIVU && v.rt == 16'd0)                           e.lat = 1;
    else if (v.op == OP_MULTU && EARLY && (v.rs == 0 || v.rt == 0)) e.lat = 1;
    else                                                            e.lat = 17;
    start = 1'b1; op = v.op; rs = v.rs; rt = v.rt;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; busy_cnt = 0; own_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      if (alu_own) own_cnt++;
      if (cyc == v.again) begin
        start = 1'b1; rs = 16'h00FF; rt = 16'h0101;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    got = sb.pop_front();
    if (!done) begin
      chk({name, " done_timeout"}, 32'(done), 32'd1);
    end else begin
      if (busy) busy_cnt++;
      chk({name, " latency"}, 32'(cyc), 32'(got.lat));
      chk({name, " hi"}, 32'(hi), 32'(got.hi));
      chk({name, " lo"}, 32'(lo), 32'(got.lo));
      chk({name, " dbz"}, 32'(dbz), 32'(got.dbz));
      chk({name, " busy_cycles"}, 32'(busy_cnt), 32'(got.lat));
      chk({name, " own_cycles"}, 32'(own_cnt), 32'(got.lat - 1));
      chk({name, " alu_idle"}, {alu_own, alu_ctrl, alu_a, 12'd0}, {1'b0, 3'b010, 16'd0, 12'd0});
    end
    if (cyc == v.again) begin
      start = 1'b1; rs = 16'h00FF; rt = 16'h0101;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, " idle_after"}, {busy, done, dbz}, {1'b0, 1'b0, got.dbz});
    chk({name, " hold"}, {hi, lo}, {got.hi, got.lo});
    @(posedge clk); #1;
    chk({name, " still_idle"}, {busy, alu_own}, 2'b00);
  endtask

  initial begin
    int   cyc, dones;
    vec_t v;
    tbl[0]  = '{OP_MULTU, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, 0};
    tbl[1]  = '{OP_MULTU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 0};
    tbl[2]  = '{OP_DIVU,  16'd100,  16'd7,    16'd2,    16'd14,   1'b0, 0};
    tbl[3]  = '{OP_DIVU,  16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 0};
    tbl[4]  = '{OP_DIVU,  16'h8000, 16'h0000, 16'h8000, 16'hFFFF, 1'b1, 0};
    tbl[5]  = '{OP_DIVU,  16'd100,  16'd7,    16'd2,    16'd14,   1'b0, 0};
    tbl[6]  = '{OP_MULTU, 16'd3,    16'd5,    16'd0,    16'd15,   1'b0, 5};
    tbl[7]  = '{OP_MULTU, 16'h00FF, 16'h0101, 16'h0000, 16'hFFFF, 1'b0, 17};
    tbl[8]  = '{OP_DIVU,  16'hFFFF, 16'h00FF, 16'h0000, 16'h0101, 1'b0, 0};
    tbl[9]  = '{OP_DIVU,  16'd5,    16'd9,    16'd5,    16'd0,    1'b0, 0};
    tbl[10] = '{OP_DIVU,  16'h8000, 16'd3,    16'd2,    16'h2AAA, 1'b0, 0};
    tbl[11] = '{OP_MULTU, 16'h8000, 16'd2,    16'h0001, 16'h0000, 1'b0, 0};
    tbl[12] = '{OP_DIVU,  16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 0};
    tbl[13] = '{OP_MULTU, 16'h0000, 16'h7777, 16'h0000, 16'h0000, 1'b0, 0};
    tbl[14] = '{OP_MULTU, 16'h7777, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0};

    rst = 1'b1; start = 1'b0; op = 1'b0; rs = '0; rt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {busy, done, dbz, alu_own}, 4'b0000);
    chk("reset_hilo", {hi, lo}, 32'd0);
    chk("reset_alu", {alu_ctrl, alu_a, alu_b}, {3'b010, 16'd0, 16'd0});
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of DIVU 1000/3.
    start = 1'b1; op = OP_DIVU; rs = 16'd1000; rt = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_hilo", {hi, lo}, 32'd0);
    chk("abort_flags", {busy, done, alu_own}, 3'b000);
    rst = 1'b0;
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    v = '{OP_DIVU, 16'd1000, 16'd3, 16'd1, 16'd333, 1'b0, 0};
    run_op(v, "div_after_abort");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
